// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator producing beam position, syncs, data enable and line/frame strobes.
// Define VIDEO_TIMING_GEN_FRAME_CNT_EN to add a 16-bit frame_cnt output.
module video_timing_gen #(
  parameter int CORDW    = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter bit H_POL    = 1'b0,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit V_POL    = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             en,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
  if (H_TOTAL - 1 > (1 << CORDW) - 1 || V_TOTAL - 1 > (1 << CORDW) - 1) begin : g_cordw_check
    $error("video_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
  end
  logic [CORDW-1:0] nx;
  logic [CORDW-1:0] ny;
  always_comb begin
    nx = (sx == H_LAST) ? '0 : sx + 1'b1;
    ny = (sx != H_LAST) ? sy : (sy == V_LAST) ? '0 : sy + 1'b1;
  end
  // Decode from the next position so every output matches the sx/sy it is registered alongside.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx    <= H_LAST;
      sy    <= V_LAST;
      hsync <= !H_POL;
      vsync <= !V_POL;
      de    <= 1'b0;
      line  <= 1'b0;
      frame <= 1'b0;
    end else begin
      line  <= en && nx == '0;
      frame <= en && nx == '0 && ny == '0;
      if (en) begin
        sx    <= nx;
        sy    <= ny;
        hsync <= (int'(nx) >= HS_BEG && int'(nx) < HS_END) ? H_POL : !H_POL;
        vsync <= (int'(ny) >= VS_BEG && int'(ny) < VS_END) ? V_POL : !V_POL;
        de    <= int'(nx) < H_ACTIVE && int'(ny) < V_ACTIVE;
      end
    end
  end
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
  always_ff @(posedge clk_pix) begin
    if (rst_pix) frame_cnt <= '0;
    else if (en && nx == '0 && ny == '0) frame_cnt <= frame_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three raster modes driven by shared random en/reset, checked against a linear pixel-index model.
module tb_video_timing_gen;
  logic clk_pix = 1'b0;
  logic rst_pix = 1'b1;
  logic en = 1'b0;
  always #5 clk_pix = ~clk_pix;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Mode table: default VGA, tiny active-high mode, mid-size active-low mode.
  int ha[3] = '{640, 8, 40};
  int hf[3] = '{16, 2, 4};
  int hs[3] = '{96, 3, 6};
  int hb[3] = '{48, 2, 10};
  int va[3] = '{480, 4, 20};
  int vf[3] = '{10, 1, 2};
  int vs[3] = '{2, 2, 3};
  int vb[3] = '{33, 1, 5};
  bit hp[3] = '{1'b0, 1'b1, 1'b0};
  bit vp[3] = '{1'b0, 1'b1, 1'b0};

  int pos[3];
  bit stb[3];
  int fcnt[3];

  logic [11:0] sx0, sy0;
  logic [3:0]  sx1, sy1;
  logic [5:0]  sx2, sy2;
  logic hs0, vs0, de0, ln0, fr0;
  logic hs1, vs1, de1, ln1, fr1;
  logic hs2, vs2, de2, ln2, fr2;
  logic [15:0] fc0, fc1, fc2;
  logic [28:0] obs[3];
  logic [15:0] obs_fc[3];

  video_timing_gen u_d0 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .en(en), .sx(sx0), .sy(sy0),
    .hsync(hs0), .vsync(vs0), .de(de0), .line(ln0), .frame(fr0)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  video_timing_gen #(
    .CORDW(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .H_POL(1'b1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .V_POL(1'b1)
  ) u_d1 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .en(en), .sx(sx1), .sy(sy1),
    .hsync(hs1), .vsync(vs1), .de(de1), .line(ln1), .frame(fr1)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  video_timing_gen #(
    .CORDW(6), .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(10), .H_POL(1'b0),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(3), .V_BP(5), .V_POL(1'b0)
  ) u_d2 (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .en(en), .sx(sx2), .sy(sy2),
    .hsync(hs2), .vsync(vs2), .de(de2), .line(ln2), .frame(fr2)
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
    , .frame_cnt(fc2)
`endif
  );

`ifndef VIDEO_TIMING_GEN_FRAME_CNT_EN
  assign fc0 = '0;
  assign fc1 = '0;
  assign fc2 = '0;
`endif

  always_comb begin
    obs[0] = {sx0, sy0, hs0, vs0, de0, ln0, fr0};
    obs[1] = {12'(sx1), 12'(sy1), hs1, vs1, de1, ln1, fr1};
    obs[2] = {12'(sx2), 12'(sy2), hs2, vs2, de2, ln2, fr2};
    obs_fc[0] = fc0;
    obs_fc[1] = fc1;
    obs_fc[2] = fc2;
  end

  function automatic int tot(int k);
    return (ha[k] + hf[k] + hs[k] + hb[k]) * (va[k] + vf[k] + vs[k] + vb[k]);
  endfunction

  // Expected outputs from a pixel index within the frame: x/y by division, syncs by range tests.
  function automatic logic [28:0] model(int k);
    int ht = ha[k] + hf[k] + hs[k] + hb[k];
    int x = pos[k] % ht;
    int y = pos[k] / ht;
    bit h_act = x >= ha[k] + hf[k] && x < ha[k] + hf[k] + hs[k];
    bit v_act = y >= va[k] + vf[k] && y < va[k] + vf[k] + vs[k];
    logic h = h_act ? hp[k] : !hp[k];
    logic v = v_act ? vp[k] : !vp[k];
    logic d = x < ha[k] && y < va[k];
    logic l = stb[k] && x == 0;
    logic f = stb[k] && pos[k] == 0;
    return {12'(x), 12'(y), h, v, d, l, f};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit e);
    @(negedge clk_pix);
    rst_pix = r;
    en = e;
    @(posedge clk_pix);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        pos[k] = tot(k) - 1;
        stb[k] = 1'b0;
        fcnt[k] = 0;
      end else if (e) begin
        pos[k] = (pos[k] + 1) % tot(k);
        stb[k] = 1'b1;
        if (pos[k] == 0) fcnt[k] = (fcnt[k] + 1) % 65536;
      end else begin
        stb[k] = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d_out@%0d", k, cyc), 32'(obs[k]), 32'(model(k)));
`ifdef VIDEO_TIMING_GEN_FRAME_CNT_EN
      check($sformatf("d%0d_fcnt@%0d", k, cyc), 32'(obs_fc[k]), 32'(fcnt[k]));
`endif
    end
    cyc++;
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 8000; i++) step(1'b0, $urandom_range(0, 99) < 40);
    repeat (2) step(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4000; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
